// File: rtl/comp_rr_arbiter.sv
// Round-robin front end that time-shares a single N-bit unsigned comparator
// between two requesters, with registered operands and a registered result.

module n_bit_comp #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         lt,
  output logic         gt,
  output logic         eq
);

  assign lt = (a < b);
  assign gt = (a > b);
  assign eq = (a == b);

endmodule

// Handshake rule for every channel: a transfer happens on a rising clk edge
// where valid and ready are both 1; valid never waits on ready, and a request
// ready is only raised for the requester being granted in that cycle.
module comp_rr_arbiter #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  output logic         rsp0_valid,
  input  logic         rsp0_ready,
  output logic         rsp1_valid,
  input  logic         rsp1_ready,
  output logic         rsp_lt,
  output logic         rsp_gt,
  output logic         rsp_eq,
  output logic         busy,
  output logic         owner
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMP  = 2'd1,
    ST_RSP  = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic         prio_q, prio_d;
  logic         owner_q, owner_d;
  logic         busy_q, busy_d;
  logic [N-1:0] a_q, a_d;
  logic [N-1:0] b_q, b_d;
  logic         lt_q, lt_d;
  logic         gt_q, gt_d;
  logic         eq_q, eq_d;
  logic         rsp0_valid_q, rsp0_valid_d;
  logic         rsp1_valid_q, rsp1_valid_d;

  logic cmp_lt, cmp_gt, cmp_eq;
  logic grant;
  logic in_idle;
  logic acc0, acc1;
  logic rsp_done;

  n_bit_comp #(.N(N)) u_comp (
    .a  (a_q),
    .b  (b_q),
    .lt (cmp_lt),
    .gt (cmp_gt),
    .eq (cmp_eq)
  );

  // With a lone requester it wins outright; on contention prio decides.
  assign grant    = (req0_valid & req1_valid) ? prio_q : req1_valid;
  assign in_idle  = (state_q == ST_IDLE) & ~rst;
  assign acc0     = in_idle & req0_valid & ~grant;
  assign acc1     = in_idle & req1_valid & grant;
  assign rsp_done = (state_q == ST_RSP) & (owner_q ? rsp1_ready : rsp0_ready);

  always_comb begin
    state_d      = state_q;
    prio_d       = prio_q;
    owner_d      = owner_q;
    a_d          = a_q;
    b_d          = b_q;
    lt_d         = lt_q;
    gt_d         = gt_q;
    eq_d         = eq_q;
    rsp0_valid_d = rsp0_valid_q;
    rsp1_valid_d = rsp1_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (acc0 | acc1) begin
          a_d     = acc1 ? req1_a : req0_a;
          b_d     = acc1 ? req1_b : req0_b;
          owner_d = acc1;
          state_d = ST_CMP;
        end
      end
      ST_CMP: begin
        lt_d         = cmp_lt;
        gt_d         = cmp_gt;
        eq_d         = cmp_eq;
        rsp0_valid_d = ~owner_q;
        rsp1_valid_d = owner_q;
        state_d      = ST_RSP;
      end
      ST_RSP: begin
        if (rsp_done) begin
          rsp0_valid_d = 1'b0;
          rsp1_valid_d = 1'b0;
          prio_d       = ~owner_q;
          state_d      = ST_IDLE;
        end
      end
      default: begin
        rsp0_valid_d = 1'b0;
        rsp1_valid_d = 1'b0;
        state_d      = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      prio_q       <= 1'b0;
      owner_q      <= 1'b0;
      busy_q       <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      lt_q         <= 1'b0;
      gt_q         <= 1'b0;
      eq_q         <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      prio_q       <= prio_d;
      owner_q      <= owner_d;
      busy_q       <= busy_d;
      a_q          <= a_d;
      b_q          <= b_d;
      lt_q         <= lt_d;
      gt_q         <= gt_d;
      eq_q         <= eq_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
    end
  end

  assign req0_ready = acc0;
  assign req1_ready = acc1;
  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp_lt     = lt_q;
  assign rsp_gt     = gt_q;
  assign rsp_eq     = eq_q;
  assign busy       = busy_q;
  assign owner      = owner_q;

endmodule

// File: tb/tb_comp_rr_arbiter.sv
// Bench for comp_rr_arbiter: directed vector table, reset-in-flight sequence,
// and random traffic checked against a grant/compare reference model.

module tb_comp_rr_arbiter;

  localparam int N = 8;

  logic         clk;
  logic         rst;
  logic         req0_valid, req0_ready;
  logic [N-1:0] req0_a, req0_b;
  logic         req1_valid, req1_ready;
  logic [N-1:0] req1_a, req1_b;
  logic         rsp0_valid, rsp0_ready;
  logic         rsp1_valid, rsp1_ready;
  logic         rsp_lt, rsp_gt, rsp_eq;
  logic         busy, owner;

  comp_rr_arbiter #(.N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp0_valid (rsp0_valid),
    .rsp0_ready (rsp0_ready),
    .rsp1_valid (rsp1_valid),
    .rsp1_ready (rsp1_ready),
    .rsp_lt     (rsp_lt),
    .rsp_gt     (rsp_gt),
    .rsp_eq     (rsp_eq),
    .busy       (busy),
    .owner      (owner)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // scoreboard entries are {owner, lt, gt, eq}
  logic [3:0] exp_q[$];
  logic [3:0] exp_e;
  bit         model_prio;

  typedef struct {
    bit         rst_before;
    bit         v0;
    bit         v1;
    logic [7:0] a0;
    logic [7:0] b0;
    logic [7:0] a1;
    logic [7:0] b1;
    int         delay;
    bit         who;
    bit         lt;
    bit         gt;
    bit         eq;
  } vec_t;

  vec_t tbl[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    step();
    step();
    rst        = 1'b0;
    model_prio = 1'b0;
  endtask

  // Called at the start of an IDLE cycle; returns at the start of the next
  // IDLE cycle after the response handshake.
  task automatic do_txn(input bit v0, input bit v1,
                        input logic [7:0] a0, input logic [7:0] b0,
                        input logic [7:0] a1, input logic [7:0] b1,
                        input int delay, input bit who,
                        input bit e_lt, input bit e_gt, input bit e_eq);
    req0_valid = v0;
    req0_a     = a0;
    req0_b     = b0;
    req1_valid = v1;
    req1_a     = a1;
    req1_b     = b1;
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    #2;
    check("accept_ready0", req0_ready, !who);
    check("accept_ready1", req1_ready, who);
    step();
    // operands change after the handshake and must not affect the result
    if (who) begin
      req1_a = 8'($urandom);
      req1_b = 8'($urandom);
    end else begin
      req0_a = 8'($urandom);
      req0_b = 8'($urandom);
    end
    #2;
    check("cmp_busy", busy, 1);
    check("cmp_owner", owner, who);
    check("cmp_ready", {req0_ready, req1_ready}, 0);
    check("cmp_rsp_valid", {rsp0_valid, rsp1_valid}, 0);
    step();
    for (int i = 0; i < delay; i++) begin
      if (who) rsp0_ready = 1'b1;
      else     rsp1_ready = 1'b1;
      #2;
      check("hold_rsp_valid", {rsp1_valid, rsp0_valid}, who ? 2 : 1);
      check("hold_result", {rsp_lt, rsp_gt, rsp_eq}, {e_lt, e_gt, e_eq});
      check("hold_no_ready", {req0_ready, req1_ready}, 0);
      check("hold_busy", busy, 1);
      step();
    end
    rsp0_ready = !who;
    rsp1_ready = who;
    #2;
    check("rsp_valid", {rsp1_valid, rsp0_valid}, who ? 2 : 1);
    check("rsp_result", {rsp_lt, rsp_gt, rsp_eq}, {e_lt, e_gt, e_eq});
    check("rsp_owner", owner, who);
    step();
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    check("done_busy", busy, 0);
    check("done_rsp_valid", {rsp0_valid, rsp1_valid}, 0);
  endtask

  initial begin
    //                rst v0 v1  a0     b0     a1     b1    dly who lt gt eq
    tbl[0]  = '{1'b0, 1, 0, 8'h05, 8'h09, 8'h00, 8'h00, 0, 0, 1, 0, 0};
    tbl[1]  = '{1'b1, 1, 1, 8'hFF, 8'h00, 8'hA5, 8'hA5, 0, 0, 0, 1, 0};
    tbl[2]  = '{1'b0, 1, 1, 8'hFF, 8'h00, 8'hA5, 8'hA5, 0, 1, 0, 0, 1};
    tbl[3]  = '{1'b0, 0, 1, 8'h00, 8'h00, 8'h80, 8'h7F, 0, 1, 0, 1, 0};
    tbl[4]  = '{1'b0, 0, 1, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1, 0, 0, 1};
    tbl[5]  = '{1'b0, 0, 1, 8'h00, 8'h00, 8'h01, 8'hFE, 0, 1, 1, 0, 0};
    tbl[6]  = '{1'b0, 1, 0, 8'h33, 8'h33, 8'h00, 8'h00, 0, 0, 0, 0, 1};
    tbl[7]  = '{1'b0, 1, 1, 8'h10, 8'h20, 8'h00, 8'h01, 5, 1, 1, 0, 0};
    tbl[8]  = '{1'b0, 1, 1, 8'h10, 8'h20, 8'h00, 8'h01, 0, 0, 1, 0, 0};
    tbl[9]  = '{1'b0, 1, 0, 8'hFF, 8'hFE, 8'h00, 8'h00, 0, 0, 0, 1, 0};
    tbl[10] = '{1'b0, 0, 1, 8'h00, 8'h00, 8'h00, 8'hFF, 2, 1, 1, 0, 0};

    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    req1_valid = 1'b0;

    // reset dominates a pending request
    rst        = 1'b1;
    req0_valid = 1'b1;
    step();
    step();
    #2;
    check("reset_ready0", req0_ready, 0);
    check("reset_busy", busy, 0);
    check("reset_owner", owner, 0);
    check("reset_result", {rsp_lt, rsp_gt, rsp_eq}, 0);
    check("reset_rsp_valid", {rsp0_valid, rsp1_valid}, 0);
    req0_valid = 1'b0;
    rst        = 1'b0;
    model_prio = 1'b0;
    step();

    // directed vector table
    for (int i = 0; i < 11; i++) begin
      if (tbl[i].rst_before) do_reset();
      do_txn(tbl[i].v0, tbl[i].v1, tbl[i].a0, tbl[i].b0, tbl[i].a1, tbl[i].b1,
             tbl[i].delay, tbl[i].who, tbl[i].lt, tbl[i].gt, tbl[i].eq);
      model_prio = !tbl[i].who;
    end

    // reset during CMP abandons the pair and restores priority to requester 0
    req1_valid = 1'b0;
    do_txn(1, 0, 8'h11, 8'h22, 8'h00, 8'h00, 0, 0, 1, 0, 0);
    req0_valid = 1'b1;
    req0_a     = 8'h44;
    req0_b     = 8'h44;
    #2;
    check("abort_accept", req0_ready, 1);
    step();
    rst        = 1'b1;
    req0_valid = 1'b0;
    rsp0_ready = 1'b1;
    step();
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_rsp_valid", {rsp0_valid, rsp1_valid}, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("abort_no_rsp", {rsp0_valid, rsp1_valid, busy}, 0);
    end
    rsp0_ready = 1'b0;
    model_prio = 1'b0;
    do_txn(1, 1, 8'h01, 8'h02, 8'h02, 8'h01, 0, 0, 1, 0, 0);
    model_prio = 1'b1;
    do_txn(1, 1, 8'h01, 8'h02, 8'h02, 8'h01, 0, 1, 0, 1, 0);
    model_prio = 1'b0;

    // random traffic: first 4 with both requesters contending from reset
    do_reset();
    for (int i = 0; i < 40; i++) begin
      bit         v0, v1, ew;
      logic [7:0] a0, b0, a1, b1;
      int         ia, ib, dly;
      if (i < 4) begin
        v0  = 1'b1;
        v1  = 1'b1;
        dly = 0;
      end else begin
        v0  = bit'($urandom_range(0, 1));
        v1  = v0 ? bit'($urandom_range(0, 1)) : 1'b1;
        dly = $urandom_range(0, 3);
      end
      a0 = 8'($urandom); b0 = 8'($urandom);
      a1 = 8'($urandom); b1 = 8'($urandom);
      if ($urandom_range(0, 5) == 0) b0 = a0;
      if ($urandom_range(0, 5) == 0) b1 = a1;
      ew = (v0 && v1) ? model_prio : v1;
      if (i < 4) check("rr_order", ew, i % 2);
      ia = ew ? int'(a1) : int'(a0);
      ib = ew ? int'(b1) : int'(b0);
      exp_q.push_back({ew, ia < ib, ia > ib, ia == ib});
      exp_e = exp_q.pop_front();
      do_txn(v0, v1, a0, b0, a1, b1, dly, exp_e[3], exp_e[2], exp_e[1], exp_e[0]);
      model_prio = !ew;
    end

    req0_valid = 1'b0;
    req1_valid = 1'b0;
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
